// File: rtl/xgmii_gen_pkg.sv
// Shared constants, state encoding and header helpers for the XGMII UDP frame generator.
package xgmii_gen_pkg;

  localparam logic [7:0]  XGMII_IDLE     = 8'h07;
  localparam logic [7:0]  XGMII_START    = 8'hFB;
  localparam logic [7:0]  XGMII_TERM     = 8'hFD;
  localparam logic [63:0] PREAMBLE_WORD  = 64'hD5555555555555FB;
  localparam logic [63:0] IDLE_WORD      = {8{XGMII_IDLE}};
  localparam int          ETH_HDR_BYTES  = 14;
  localparam int          IP_HDR_BYTES   = 20;
  localparam int          UDP_HDR_BYTES  = 8;
  localparam int          HDR_BYTES      = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_PREAMBLE,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } gen_state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;
  } gen_cfg_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Fixed header words are version/IHL, flags and TTL/protocol; checksum field is zero.
  function automatic logic [15:0] ipv4_checksum(input logic [15:0] tot_len, input logic [15:0] id,
                                                input logic [31:0] src, input logic [31:0] dst);
    logic [31:0] s;
    s = 32'h0000_4500 + 32'(tot_len) + 32'(id) + 32'h0000_4000 + 32'h0000_4011
      + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/eth_crc32_d64.sv
// Ethernet CRC-32 (reflected) over up to 8 bytes per cycle; lane 0 is processed first.
module eth_crc32_d64
  import xgmii_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        init_i,
  input  logic        valid_i,
  input  logic [63:0] data_i,
  input  logic [3:0]  nbytes_i,
  output logic [31:0] crc_o,
  output logic [31:0] crc_next_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  logic [31:0] crc_q, crc_d, c_s, step_s;
  logic        fb_s;

  // init_i seeds the running value so the first word of a frame needs no extra cycle.
  always_comb begin
    c_s    = init_i ? 32'hFFFF_FFFF : crc_q;
    step_s = 32'h0;
    fb_s   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step_s = c_s;
      for (int j = 0; j < 8; j++) begin
        fb_s   = step_s[0] ^ data_i[8*i+j];
        step_s = {1'b0, step_s[31:1]} ^ (POLY_REFL & {32{fb_s}});
      end
      c_s = (4'(i) < nbytes_i) ? step_s : c_s;
    end
    crc_next_o = c_s;
  end

  always_comb begin
    if (clear_i) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (valid_i) begin
      crc_d = crc_next_o;
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/xgmii_udp_frame_generator.sv
// Builds Ethernet/IPv4/UDP frames and drives them onto a 64-bit XGMII TX bus.
// Define XGMII_GEN_SEQNUM_EN to carry the frame count in payload bytes 0..3.
module xgmii_udp_frame_generator
  import xgmii_gen_pkg::*;
#(
  parameter int IFG_WORDS   = 3,
  parameter int PAYLOAD_MIN = 18,
  parameter int PAYLOAD_MAX = 1472
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [47:0] i_src_mac,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [15:0] i_payload_len,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_frame_count,
  output logic [63:0] o_xgmii_tx_data,
  output logic [7:0]  o_xgmii_tx_control
);

  gen_state_t  state_q, state_d;
  gen_cfg_t    cfg_q, cfg_d;
  logic [15:0] plen_q, plen_d, flen_q, flen_d, csum_q, csum_d, b_q, b_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [31:0] count_q, count_d;
  logic        done_q, done_d, busy_q;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;

  logic [15:0] plen_s, idx_s, k_s, rem_s;
  logic [1:0]  fcs_lane_s;
  logic [31:0] crc_s, crc_next_s, fcs_s;
  logic [3:0]  nbytes_s;
  logic        crc_valid_s;
  logic [HDR_BYTES*8-1:0] hdr_s;

  assign plen_s = (cfg_q.payload_len < 16'(PAYLOAD_MIN)) ? 16'(PAYLOAD_MIN) :
                  (cfg_q.payload_len > 16'(PAYLOAD_MAX)) ? 16'(PAYLOAD_MAX) : cfg_q.payload_len;

  assign hdr_s = {cfg_q.dst_mac, cfg_q.src_mac, ETHERTYPE_IPV4,
                  8'h45, 8'h00, 16'(IP_HDR_BYTES + UDP_HDR_BYTES) + plen_q, count_q[15:0],
                  16'h4000, 8'h40, 8'h11, csum_q, cfg_q.src_ip, cfg_q.dst_ip,
                  cfg_q.src_port, cfg_q.dst_port, 16'(UDP_HDR_BYTES) + plen_q, 16'h0000};

  assign rem_s       = flen_q - b_q;
  assign nbytes_s    = (rem_s > 16'd8) ? 4'd8 : rem_s[3:0];
  assign crc_valid_s = ((state_q == ST_DATA) || (state_q == ST_TERM)) && (b_q < flen_q);
  // Once all data has been folded in, the register holds the final CRC.
  assign fcs_s       = (b_q < flen_q) ? ~crc_next_s : ~crc_s;

  eth_crc32_d64 u_crc (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .clear_i    (state_q == ST_CALC),
    .init_i     (b_q == 16'd0),
    .valid_i    (crc_valid_s),
    .data_i     (txd_d),
    .nbytes_i   (nbytes_s),
    .crc_o      (crc_s),
    .crc_next_o (crc_next_s)
  );

  // Next-state, per-frame bookkeeping and counters.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    plen_d  = plen_q;
    flen_d  = flen_q;
    csum_d  = csum_q;
    b_d     = b_q;
    ifg_d   = ifg_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cfg_d.dst_mac     = i_dst_mac;
          cfg_d.src_mac     = i_src_mac;
          cfg_d.src_ip      = i_src_ip;
          cfg_d.dst_ip      = i_dst_ip;
          cfg_d.src_port    = i_src_port;
          cfg_d.dst_port    = i_dst_port;
          cfg_d.payload_len = i_payload_len;
          state_d           = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        plen_d  = plen_s;
        flen_d  = plen_s + 16'(HDR_BYTES);
        csum_d  = ipv4_checksum(16'(IP_HDR_BYTES + UDP_HDR_BYTES) + plen_s, count_q[15:0],
                                cfg_q.src_ip, cfg_q.dst_ip);
        b_d     = 16'd0;
        state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: state_d = ST_DATA;
      ST_DATA: begin
        b_d = b_q + 16'd8;
        // The next word is the terminate word once it will hold byte N+4.
        if ((flen_q + 16'd4) < (b_q + 16'd16)) begin
          state_d = ST_TERM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_TERM: begin
        done_d  = 1'b1;
        count_d = count_q + 32'd1;
        ifg_d   = 8'd0;
        state_d = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_q == 8'(IFG_WORDS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ifg_d = ifg_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-lane byte mux: header, payload, FCS, then terminate and idle fill.
  always_comb begin
    txd_d      = IDLE_WORD;
    txc_d      = 8'hFF;
    idx_s      = 16'd0;
    k_s        = 16'd0;
    fcs_lane_s = 2'd0;
    case (state_q)
      ST_PREAMBLE: begin
        txd_d = PREAMBLE_WORD;
        txc_d = 8'h01;
      end
      ST_DATA, ST_TERM: begin
        for (int lane = 0; lane < 8; lane++) begin
          idx_s      = b_q + 16'(lane);
          k_s        = idx_s - 16'(HDR_BYTES);
          fcs_lane_s = 2'(idx_s - flen_q);
          if (idx_s < 16'(HDR_BYTES)) begin
            txd_d[8*lane +: 8] = hdr_s[8*(HDR_BYTES-1-int'(idx_s)) +: 8];
            txc_d[lane]        = 1'b0;
          end else if (idx_s < flen_q) begin
`ifdef XGMII_GEN_SEQNUM_EN
            txd_d[8*lane +: 8] = (k_s < 16'd4) ? count_q[{~k_s[1:0], 3'b000} +: 8] : k_s[7:0];
`else
            txd_d[8*lane +: 8] = k_s[7:0];
`endif
            txc_d[lane]        = 1'b0;
          end else if (idx_s < (flen_q + 16'd4)) begin
            txd_d[8*lane +: 8] = fcs_s[{fcs_lane_s, 3'b000} +: 8];
            txc_d[lane]        = 1'b0;
          end else if (idx_s == (flen_q + 16'd4)) begin
            txd_d[8*lane +: 8] = XGMII_TERM;
          end else begin
            txd_d[8*lane +: 8] = XGMII_IDLE;
          end
        end
      end
      default: begin
        txd_d = IDLE_WORD;
        txc_d = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      plen_q  <= 16'd0;
      flen_q  <= 16'd0;
      csum_q  <= 16'd0;
      b_q     <= 16'd0;
      ifg_q   <= 8'd0;
      count_q <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      txd_q   <= IDLE_WORD;
      txc_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      plen_q  <= plen_d;
      flen_q  <= flen_d;
      csum_q  <= csum_d;
      b_q     <= b_d;
      ifg_q   <= ifg_d;
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      txd_q   <= txd_d;
      txc_q   <= txc_d;
    end
  end

  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_frame_count      = count_q;
  assign o_xgmii_tx_data    = txd_q;
  assign o_xgmii_tx_control = txc_q;

endmodule

// File: tb/tb_xgmii_udp_frame_generator.sv
// Scoreboard bench: expected XGMII words and per-frame facts are queued at stimulus time.
module tb_xgmii_udp_frame_generator;
  import xgmii_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [47:0] src_mac, dst_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, plen;
  logic        busy, done;
  logic [31:0] fcount;
  logic [63:0] txd;
  logic [7:0]  txc;

  always #5 clk = ~clk;

  xgmii_udp_frame_generator dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_src_mac(src_mac), .i_dst_mac(dst_mac), .i_src_ip(src_ip), .i_dst_ip(dst_ip),
    .i_src_port(src_port), .i_dst_port(dst_port), .i_payload_len(plen),
    .o_busy(busy), .o_done(done), .o_frame_count(fcount),
    .o_xgmii_tx_data(txd), .o_xgmii_tx_control(txc)
  );

  typedef struct { logic [63:0] d; logic [7:0] c; } word_t;
  typedef struct { int cnt_after; int tot_len; int udp_len; int csum; bit chk_period; } frame_exp_t;

  word_t      exp_words[$];
  frame_exp_t exp_frames[$];
  byte unsigned cap[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  last_pre = -1;
  localparam int BURST_PERIOD = (8 + 60 + 4 + 1 + 7) / 8 + 3 + 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int j = 0; j < 8; j++) begin
      if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic expect_frame(input int p_raw, input int cnt, input int tot_exp, input int udp_exp,
                              input int csum_exp, input bit per);
    int p, sum, tl, ul;
    byte unsigned f[$];
    logic [8:0] s[$];
    logic [31:0] c;
    word_t w;
    frame_exp_t fe;
    p  = (p_raw < 18) ? 18 : ((p_raw > 1472) ? 1472 : p_raw);
    tl = 28 + p;
    ul = 8 + p;
    for (int i = 0; i < 6; i++) f.push_back(dst_mac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src_mac[47-8*i -: 8]);
    f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h45); f.push_back(8'h00); f.push_back(8'(tl >> 8)); f.push_back(8'(tl));
    f.push_back(8'(cnt >> 8)); f.push_back(8'(cnt));
    f.push_back(8'h40); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h11);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < 4; i++) f.push_back(src_ip[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) f.push_back(dst_ip[31-8*i -: 8]);
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {f[i], f[i+1]};
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = ~sum & 32'hFFFF;
    f[24] = 8'(sum >> 8);
    f[25] = 8'(sum);
    f.push_back(src_port[15:8]); f.push_back(src_port[7:0]);
    f.push_back(dst_port[15:8]); f.push_back(dst_port[7:0]);
    f.push_back(8'(ul >> 8)); f.push_back(8'(ul)); f.push_back(8'h00); f.push_back(8'h00);
    for (int k = 0; k < p; k++) begin
`ifdef XGMII_GEN_SEQNUM_EN
      if (k < 4) f.push_back(8'(cnt >> (8 * (3 - k))));
      else       f.push_back(8'(k));
`else
      f.push_back(8'(k));
`endif
    end
    c = 32'hFFFF_FFFF;
    foreach (f[i]) c = crc_step(c, f[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    foreach (f[i]) s.push_back({1'b0, f[i]});
    s.push_back({1'b1, 8'hFD});
    while (s.size() % 8 != 0) s.push_back({1'b1, 8'h07});
    w.d = PREAMBLE_WORD;
    w.c = 8'h01;
    exp_words.push_back(w);
    for (int wi = 0; wi < s.size() / 8; wi++) begin
      for (int l = 0; l < 8; l++) begin
        w.d[8*l +: 8] = s[8*wi+l][7:0];
        w.c[l]        = s[8*wi+l][8];
      end
      exp_words.push_back(w);
    end
    fe = '{cnt + 1, tot_exp, udp_exp, csum_exp, per};
    exp_frames.push_back(fe);
  endtask

  task automatic end_frame();
    frame_exp_t fe;
    logic [31:0] c;
    int sum;
    if (exp_frames.size() == 0 || cap.size() < 42) begin
      checks++;
      errors++;
      $display("FAIL frame_end: unexpected terminate, captured %0d bytes", cap.size());
      return;
    end
    fe = exp_frames.pop_front();
    check("frame_count", 64'(fcount), 64'(fe.cnt_after));
    c = 32'hFFFF_FFFF;
    foreach (cap[i]) c = crc_step(c, cap[i]);
    for (int i = 0; i < 16; i++) begin
      c[i] ^= c[31-i];
      c[31-i] ^= c[i];
      c[i] ^= c[31-i];
    end
    check("crc_residue", 64'(c), 64'(CRC32_RESIDUE));
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {cap[i], cap[i+1]};
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    check("ip_resum", 64'(sum), 64'h0000_FFFF);
    check("ip_total_len", 64'({cap[16], cap[17]}), 64'(fe.tot_len));
    check("udp_len", 64'({cap[38], cap[39]}), 64'(fe.udp_len));
    if (fe.csum >= 0) check("ip_csum", 64'({cap[24], cap[25]}), 64'(fe.csum));
  endtask

  // Monitor: every non-idle word must match the head of the expected queue.
  always @(negedge clk) begin
    word_t w;
    bit term;
    cyc++;
    if (mon_en && !(txd == IDLE_WORD && txc == 8'hFF)) begin
      if (exp_words.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h/%h expected idle", txd, txc);
      end else begin
        w = exp_words.pop_front();
        check("txd", txd, w.d);
        check("txc", 64'(txc), 64'(w.c));
        if (txd == PREAMBLE_WORD && txc == 8'h01) begin
          cap.delete();
          if (last_pre >= 0 && exp_frames.size() > 0 && exp_frames[0].chk_period)
            check("frame_period", 64'(cyc - last_pre), 64'(BURST_PERIOD));
          last_pre = cyc;
        end else begin
          term = 1'b0;
          for (int l = 0; l < 8; l++) begin
            if (!txc[l]) cap.push_back(txd[8*l +: 8]);
            else if (txd[8*l +: 8] == XGMII_TERM) term = 1'b1;
          end
          check("done", 64'(done), 64'(term));
          if (term) end_frame();
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_words.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still expected", exp_words.size());
    end
    repeat (20) @(posedge clk);
  endtask

  initial begin
    int dn, n;
    rst = 1'b1; start = 1'b0;
    dst_mac = 48'h5A51_5253_5455; src_mac = 48'h0200_0000_0001;
    src_ip = 32'h0A0A_3264; dst_ip = 32'h0A0A_3201;
    src_port = 16'd1234; dst_port = 16'd1234; plen = 16'd18;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 64'h0707070707070707);
    check("rst_txc", 64'(txc), 64'hFF);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_count", 64'(fcount), 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // P=18 with hand-computed checksum 0xC246, latency check and an ignored mid-frame start.
    expect_frame(18, 0, 46, 26, 16'hC246, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'h1);
    @(negedge clk);
    check("latency_calc_idle", txd, IDLE_WORD);
    @(negedge clk);
    check("latency_preamble", txd, PREAMBLE_WORD);
    pulse_start();
    wait_drain();

    plen = 16'd19;   expect_frame(19, 1, 47, 27, -1, 1'b0);     pulse_start(); wait_drain();
    plen = 16'd5;    expect_frame(5, 2, 46, 26, -1, 1'b0);      pulse_start(); wait_drain();
    plen = 16'd2000; expect_frame(2000, 3, 1500, 1480, -1, 1'b0); pulse_start(); wait_drain();

    // Three back-to-back frames with i_start held high.
    plen = 16'd18;
    expect_frame(18, 4, 46, 26, -1, 1'b0);
    expect_frame(18, 5, 46, 26, -1, 1'b1);
    expect_frame(18, 6, 46, 26, -1, 1'b1);
    @(posedge clk); #1 start = 1'b1;
    dn = 0;
    n = 0;
    while (dn < 3 && n < 2000) begin
      @(negedge clk);
      if (done) dn++;
      n++;
    end
    start = 1'b0;
    if (dn < 3) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: saw %0d done pulses, expected 3", dn);
    end
    wait_drain();
    check("count_after_burst", 64'(fcount), 64'd7);

    // Reset while word 4 of a frame is on the bus.
    mon_en = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_txd", txd, IDLE_WORD);
    check("abort_txc", 64'(txc), 64'hFF);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_count", 64'(fcount), 64'h0);
    repeat (20) @(negedge clk);
    check("abort_stays_idle", txd, IDLE_WORD);
    cap.delete();
    last_pre = -1;
    mon_en = 1'b1;
    expect_frame(18, 0, 46, 26, 16'hC246, 1'b0);
    pulse_start();
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
